// File: rtl/udma_tx_l2_arbiter.sv
// Round-robin arbiter sharing the uDMA L2 read port among N_CH TX channels,
// with an in-order ID FIFO for response routing. Option: UDMA_TX_ARB_PRIO_EN (channel 0 absolute priority).
module udma_tx_l2_arbiter #(
    parameter int N_CH           = 4,
    parameter int L2_AWIDTH_NOAL = 21,
    parameter int OUTSTD         = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [N_CH-1:0]                        ch_req_i,
    input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]    ch_addr_i,
    input  logic [N_CH-1:0][1:0]                   ch_datasize_i,
    output logic [N_CH-1:0]                        ch_gnt_o,
    output logic [N_CH-1:0]                        ch_valid_o,
    output logic [31:0]                            ch_data_o,
    output logic                                   l2_req_o,
    output logic [L2_AWIDTH_NOAL-1:0]              l2_addr_o,
    input  logic                                   l2_gnt_i,
    input  logic                                   l2_rvalid_i,
    input  logic [31:0]                            l2_rdata_i
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = $clog2(OUTSTD + 1);
    localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTD);
`ifdef UDMA_TX_ARB_PRIO_EN
    localparam logic [IW-1:0] PTR_RST = IW'(1);
`else
    localparam logic [IW-1:0] PTR_RST = '0;
`endif

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   lock_id;
    logic [1:0]      lock_off;
    logic [1:0]      lock_size;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   win_id;
    logic            win_vld;
    int              win_dist;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [IW-1:0]   fifo_id   [OUTSTD];
    logic [1:0]      fifo_off  [OUTSTD];
    logic [1:0]      fifo_size [OUTSTD];
    logic            push;
    logic            pop;
    logic [31:0]     shifted;
    logic [31:0]     aligned;

    // Rotation distance from the pointer; the smallest requesting distance wins.
    function automatic int rr_dist(input int j, input int p);
`ifdef UDMA_TX_ARB_PRIO_EN
        if (j == 0) return -1;
        return (j - p + N_CH - 1) % (N_CH - 1);
`else
        return (j - p + N_CH) % N_CH;
`endif
    endfunction

    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        win_dist = N_CH;
        for (int j = 0; j < N_CH; j++) begin
            if (ch_req_i[j] && (rr_dist(j, int'(ptr)) < win_dist)) begin
                win_vld  = 1'b1;
                win_id   = IW'(j);
                win_dist = rr_dist(j, int'(ptr));
            end
        end
    end

    always_comb begin
`ifdef UDMA_TX_ARB_PRIO_EN
        if (lock_id == '0)
            next_ptr = ptr;
        else if (int'(lock_id) == N_CH - 1)
            next_ptr = IW'(1);
        else
            next_ptr = lock_id + 1'b1;
`else
        if (int'(lock_id) == N_CH - 1)
            next_ptr = '0;
        else
            next_ptr = lock_id + 1'b1;
`endif
    end

    assign push = (state == LOCK) && l2_gnt_i;
    assign pop  = l2_rvalid_i && (cnt != '0);

    always_comb begin
        ch_gnt_o = '0;
        if (push)
            ch_gnt_o[lock_id] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            lock_id   <= '0;
            lock_off  <= '0;
            lock_size <= '0;
            l2_req_o  <= 1'b0;
            l2_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld && (cnt < CNT_MAX)) begin
                        state     <= LOCK;
                        lock_id   <= win_id;
                        lock_off  <= ch_addr_i[win_id][1:0];
                        lock_size <= ch_datasize_i[win_id];
                        l2_req_o  <= 1'b1;
                        l2_addr_o <= {ch_addr_i[win_id][L2_AWIDTH_NOAL-1:2], 2'b00};
                    end
                end
                LOCK: begin
                    if (l2_gnt_i) begin
                        state    <= IDLE;
                        l2_req_o <= 1'b0;
                        ptr      <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= (int'(wr_ptr) == OUTSTD - 1) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (int'(rd_ptr) == OUTSTD - 1) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Entries are only read while cnt marks them valid, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wr_ptr]   <= lock_id;
            fifo_off[wr_ptr]  <= lock_off;
            fifo_size[wr_ptr] <= lock_size;
        end
    end

    always_comb begin
        shifted = l2_rdata_i >> {fifo_off[rd_ptr], 3'b000};
        case (fifo_size[rd_ptr])
            2'd0:    aligned = {24'd0, shifted[7:0]};
            2'd1:    aligned = {16'd0, shifted[15:0]};
            default: aligned = shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ch_valid_o <= '0;
            ch_data_o  <= '0;
        end else begin
            ch_valid_o <= '0;
            if (pop) begin
                ch_valid_o[fifo_id[rd_ptr]] <= 1'b1;
                ch_data_o                   <= aligned;
            end
        end
    end

endmodule

// File: tb/tb_udma_tx_l2_arbiter.sv
// Bench for udma_tx_l2_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level model.
module tb_udma_tx_l2_arbiter;

    localparam int N_CH   = 4;
    localparam int AW     = 21;
    localparam int OUTSTD = 2;
`ifdef UDMA_TX_ARB_PRIO_EN
    localparam int PTR0 = 1;
`else
    localparam int PTR0 = 0;
`endif

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [N_CH-1:0]               ch_req_i;
    logic [N_CH-1:0][AW-1:0]       ch_addr_i;
    logic [N_CH-1:0][1:0]          ch_datasize_i;
    logic [N_CH-1:0]               ch_gnt_o;
    logic [N_CH-1:0]               ch_valid_o;
    logic [31:0]                   ch_data_o;
    logic                          l2_req_o;
    logic [AW-1:0]                 l2_addr_o;
    logic                          l2_gnt_i;
    logic                          l2_rvalid_i;
    logic [31:0]                   l2_rdata_i;

    udma_tx_l2_arbiter #(.N_CH(N_CH), .L2_AWIDTH_NOAL(AW), .OUTSTD(OUTSTD)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch_req_i(ch_req_i), .ch_addr_i(ch_addr_i), .ch_datasize_i(ch_datasize_i),
        .ch_gnt_o(ch_gnt_o), .ch_valid_o(ch_valid_o), .ch_data_o(ch_data_o),
        .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_gnt_i(l2_gnt_i),
        .l2_rvalid_i(l2_rvalid_i), .l2_rdata_i(l2_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       id;
        logic [1:0] off;
        logic [1:0] sz;
    } ent_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus state
    logic                    d_rst, d_gnt, d_rvalid, refill;
    logic [31:0]             d_rdata;
    logic [N_CH-1:0]         pend;
    logic [N_CH-1:0][AW-1:0] paddr;
    logic [N_CH-1:0][1:0]    psize;

    // reference model
    logic          m_locked;
    int            m_id;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_sz;
    int            m_ptr;
    logic [N_CH-1:0] m_vld;
    logic [31:0]   m_data;
    ent_t          q[$];
    int            gq[$];
    int            gcyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] s;
        s = d >> (8 * int'(off));
        if (sz == 2'd0) return s & 32'h0000_00FF;
        if (sz == 2'd1) return s & 32'h0000_FFFF;
        return s;
    endfunction

    // First requester in the fairness order starting from p.
    function automatic int pick(input logic [N_CH-1:0] r, input int p);
`ifdef UDMA_TX_ARB_PRIO_EN
        if (r[0]) return 0;
        for (int k = 0; k < N_CH - 1; k++) begin
            int c;
            c = 1 + ((p - 1 + k) % (N_CH - 1));
            if (r[c]) return c;
        end
`else
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (p + k) % N_CH;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic int after(input int id, input int p);
`ifdef UDMA_TX_ARB_PRIO_EN
        if (id == 0) return p;
        return (id % (N_CH - 1)) + 1;
`else
        return (id + 1) % N_CH;
`endif
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        q.delete();
        m_ptr  = PTR0;
        m_vld  = '0;
        m_data = '0;
    endtask

    task automatic cycle();
        logic [N_CH-1:0] e_gnt;
        int   occ;
        int   w;
        ent_t e;
        @(negedge clk_i);
        rst_i         = d_rst;
        ch_req_i      = pend;
        ch_addr_i     = paddr;
        ch_datasize_i = psize;
        l2_gnt_i      = d_gnt;
        l2_rvalid_i   = d_rvalid;
        l2_rdata_i    = d_rdata;
        #1;
        cyc++;
        if (d_rst) begin
            check("rst_l2_req",   32'(l2_req_o),   32'd0);
            check("rst_l2_addr",  32'(l2_addr_o),  32'd0);
            check("rst_ch_gnt",   32'(ch_gnt_o),   32'd0);
            check("rst_ch_valid", 32'(ch_valid_o), 32'd0);
            check("rst_ch_data",  ch_data_o,       32'd0);
            model_reset();
            return;
        end
        e_gnt = '0;
        if (m_locked && d_gnt) e_gnt[m_id] = 1'b1;
        check("l2_req", 32'(l2_req_o), 32'(m_locked));
        if (m_locked) check("l2_addr", 32'(l2_addr_o), 32'({m_addr[AW-1:2], 2'b00}));
        check("ch_gnt",   32'(ch_gnt_o),   32'(e_gnt));
        check("ch_valid", 32'(ch_valid_o), 32'(m_vld));
        check("ch_data",  ch_data_o,       m_data);
        for (int j = 0; j < N_CH; j++)
            if (ch_gnt_o[j]) begin
                gq.push_back(j);
                gcyc.push_back(cyc);
            end

        occ   = q.size();
        m_vld = '0;
        if (d_rvalid && occ > 0) begin
            e = q.pop_front();
            m_vld[e.id] = 1'b1;
            m_data = align(d_rdata, e.off, e.sz);
        end
        if (m_locked && d_gnt) begin
            e.id = m_id; e.off = m_addr[1:0]; e.sz = m_sz;
            q.push_back(e);
            m_ptr    = after(m_id, m_ptr);
            m_locked = 1'b0;
            if (refill) begin
                paddr[m_id] = AW'($urandom);
                psize[m_id] = 2'($urandom);
            end else begin
                pend[m_id] = 1'b0;
            end
        end else if (!m_locked && pend != '0 && occ < OUTSTD) begin
            w        = pick(pend, m_ptr);
            m_locked = 1'b1;
            m_id     = w;
            m_addr   = paddr[w];
            m_sz     = psize[w];
        end
    endtask

    task automatic rst_cycle();
        d_rst = 1'b1; d_gnt = 1'b0; d_rvalid = 1'b0;
        cycle();
        d_rst = 1'b0;
        gq.delete(); gcyc.delete();
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [1:0] sz,
                           input logic [31:0] rd, input logic [31:0] exp_data);
        refill = 1'b0; pend = '0;
        pend[ch] = 1'b1; paddr[ch] = a; psize[ch] = sz;
        d_gnt = 1'b1; d_rvalid = 1'b0;
        cycle();
        cycle();
        check("dir_addr", 32'(l2_addr_o), 32'({a[AW-1:2], 2'b00}));
        check("dir_gnt",  32'(ch_gnt_o),  32'(1 << ch));
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = rd;
        cycle();
        d_rvalid = 1'b0;
        cycle();
        check("dir_valid", 32'(ch_valid_o), 32'(1 << ch));
        check("dir_data",  ch_data_o,       exp_data);
    endtask

    initial begin
        int exp_order[6];
        logic [AW-1:0] ha;
        rst_i = 1'b1; ch_req_i = '0; ch_addr_i = '0; ch_datasize_i = '0;
        l2_gnt_i = 1'b0; l2_rvalid_i = 1'b0; l2_rdata_i = '0;
        d_rst = 1'b1; d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0; refill = 1'b0;
        pend = '0; paddr = '0; psize = '0;
        model_reset();
        rst_cycle();

        // single reads and alignment
        do_read(2, AW'(21'h00103), 2'd0, 32'hAABBCCDD, 32'h0000_00AA);
        do_read(1, AW'(21'h00002), 2'd1, 32'h12345678, 32'h0000_1234);
        do_read(3, AW'(21'h001F0), 2'd2, 32'h12345678, 32'h1234_5678);
        do_read(0, AW'(21'h00045), 2'd0, 32'hAABBCCDD, 32'h0000_00CC);
        do_read(2, AW'(21'h00011), 2'd3, 32'h12345678, 32'h0012_3456);

        // fairness / priority with continuous requests
        rst_cycle();
        refill = 1'b1; d_gnt = 1'b1; d_rvalid = 1'b1;
`ifdef UDMA_TX_ARB_PRIO_EN
        pend = 4'b1001;
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        pend = '1;
        exp_order = '{0, 1, 2, 3, 0, 1};
`endif
        repeat (12) cycle();
        check("rr_count", gq.size(), 6);
        for (int k = 0; k < 6; k++)
            check("rr_id", (k < gq.size()) ? gq[k] : -1, exp_order[k]);
        for (int k = 1; k < 6; k++)
            check("rr_gap", (k < gcyc.size()) ? gcyc[k] - gcyc[k-1] : -1, 2);

        // outstanding limit
        rst_cycle();
        refill = 1'b1; pend = '1; d_gnt = 1'b1; d_rvalid = 1'b0;
        repeat (10) cycle();
        check("outstd_grants", gq.size(), 2);
        check("outstd_req_off", 32'(l2_req_o), 32'd0);
        d_rvalid = 1'b1;
        cycle();
        d_rvalid = 1'b0;
        cycle();
        check("outstd_relock_wait", 32'(l2_req_o), 32'd0);
        cycle();
        check("outstd_relock", 32'(l2_req_o), 32'd1);
        check("outstd_third", gq.size(), 3);
        d_rvalid = 1'b1;
        repeat (8) cycle();

        // held lock
        rst_cycle();
        refill = 1'b0; pend = '0; d_gnt = 1'b0; d_rvalid = 1'b0;
        ha = AW'(21'h1ABCD);
        pend[1] = 1'b1; paddr[1] = ha; psize[1] = 2'd2;
        cycle();
        repeat (5) begin
            cycle();
            check("hold_req",  32'(l2_req_o),  32'd1);
            check("hold_addr", 32'(l2_addr_o), 32'(21'h1ABCC));
            check("hold_nognt", 32'(ch_gnt_o), 32'd0);
        end
        d_gnt = 1'b1;
        cycle();
        check("hold_gnt", 32'(ch_gnt_o), 32'd2);
        cycle();
        check("hold_single", gq.size(), 1);

        // reset with reads outstanding
        rst_cycle();
        pend = 4'b0011; d_gnt = 1'b1; d_rvalid = 1'b0;
        repeat (5) cycle();
        check("prerst_grants", gq.size(), 2);
        rst_cycle();
        pend = '0; d_rvalid = 1'b1; d_rdata = 32'hDEADBEEF;
        repeat (2) cycle();
        d_rvalid = 1'b0;
        repeat (2) begin
            cycle();
            check("stray_valid", 32'(ch_valid_o), 32'd0);
        end
        pend = 4'b1100; d_gnt = 1'b1;
        repeat (5) cycle();
        check("postrst_grants", gq.size(), 2);

        // randomized traffic
        rst_cycle();
        refill = 1'b0;
        repeat (3000) begin
            for (int j = 0; j < N_CH; j++)
                if (!pend[j] && ($urandom_range(3) == 0)) begin
                    pend[j]  = 1'b1;
                    paddr[j] = AW'($urandom);
                    psize[j] = 2'($urandom);
                end
            d_gnt    = ($urandom_range(2) != 0);
            d_rvalid = ($urandom_range(2) != 0);
            d_rdata  = $urandom;
            d_rst    = ($urandom_range(499) == 0);
            cycle();
            d_rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_tx_l2_arbiter.md
# udma_tx_l2_arbiter

Shares the uDMA L2 read port among `N_CH` linear TX channels. Each channel presents a req/gnt read request with address and datasize. The block round-robin arbitrates, holds the winning request stable toward L2 until it is granted, and tracks up to `OUTSTD` outstanding reads in an ID FIFO. Returning read data is byte-aligned and routed back to the issuing channel. It sits between the per-channel TX address generators and the L2 interconnect port of the uDMA core.

## Interface
- `N_CH`, default 4: number of TX channels, 2..16.
- `L2_AWIDTH_NOAL`, default 21: byte address width.
- `OUTSTD`, default 2: maximum outstanding L2 reads, 1..8; also the ID FIFO depth.
- `clk_i`, in, 1: sole clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `ch_req_i`, in, N_CH: per-channel read request.
- `ch_addr_i`, in, N_CH×L2_AWIDTH_NOAL: per-channel byte address.
- `ch_datasize_i`, in, N_CH×2: 0 = byte, 1 = half, 2 = word.
- `ch_gnt_o`, out, N_CH: one-cycle pulse when that channel's request is accepted by L2.
- `ch_valid_o`, out, N_CH: one-hot, one-cycle pulse marking response data for that channel.
- `ch_data_o`, out, 32: aligned, zero-extended response data, shared by all channels.
- `l2_req_o`, out, 1: L2 read request.
- `l2_addr_o`, out, L2_AWIDTH_NOAL: word-aligned address, bits [1:0] = 0.
- `l2_gnt_i`, in, 1: L2 accepts the request in the current cycle.
- `l2_rvalid_i`, in, 1: L2 read data valid; earliest one cycle after the matching `l2_gnt_i`.
- `l2_rdata_i`, in, 32: L2 read data.

## Operation
- **FSM states:**
  - IDLE: no request driven.
  - LOCK: request driven, held toward L2.
- **IDLE → LOCK:** when any `ch_req_i` is high and `cnt < OUTSTD`. The winner is picked round-robin starting at `ptr`. The winner ID, `addr[1:0]` and datasize are latched.
- **In LOCK:**
  - `l2_req_o` = 1.
  - `l2_addr_o` = latched address with bits [1:0] cleared.
  - All of these stay constant until `l2_gnt_i`.
- **LOCK on `l2_gnt_i`:**
  - `ch_gnt_o[id]` pulses in the same cycle, combinational from `l2_gnt_i`.
  - {id, addr[1:0], datasize} is pushed to the ID FIFO and `cnt` increments.
  - `ptr` becomes id+1 mod N_CH.
  - Next state is IDLE. There is no back-to-back issue, so there is a minimum of 2 cycles between grants.
- **Channel rule:** a channel must keep `ch_req_i` and its address stable until `ch_gnt_o`. If `ch_req_i` drops in LOCK, the block still completes the locked request.
- **On `l2_rvalid_i` with FIFO non-empty:**
  - The FIFO head is popped and `cnt` decrements.
  - Data = `l2_rdata_i >> (8*addr[1:0])`, masked to 8/16/32 bits by datasize.
  - Datasize 3 is treated as word.
  - Data is registered into `ch_data_o` and `ch_valid_o[id]` pulses in the next cycle.
- **`l2_rvalid_i` with FIFO empty:** ignored, with no output change.
- **Simultaneous push (gnt) and pop (rvalid):** `cnt` is unchanged and both take effect.
- **Flow control toward channels:** channels accept `ch_valid_o` unconditionally. They reserve buffer space before asserting `ch_req_i`.

## Timing
- **Reset values:**
  - `ch_gnt_o` = 0, `ch_valid_o` = 0, `ch_data_o` = 0.
  - `l2_req_o` = 0, `l2_addr_o` = 0.
  - `ptr` = 0, `cnt` = 0, FIFO empty, state IDLE.
- **Request path:** `ch_req_i` high in cycle T gives `l2_req_o` high in T+1 (registered lock).
- **Response path:** `l2_rvalid_i` in cycle R gives `ch_valid_o` / `ch_data_o` in R+1. `ch_data_o` holds its value between pulses.
- **Throughput:** at most one read per 2 cycles. Responses return in issue order.
- **`cnt == OUTSTD`:** no new lock is taken. A pop in cycle C allows a lock decision in C+1.
- **Reset mid-operation:**
  - The lock and FIFO are cleared immediately.
  - Responses arriving after reset for pre-reset requests are dropped, because the FIFO is empty.

## Configuration
- **`UDMA_TX_ARB_PRIO_EN` defined:** channel 0 has absolute priority. Channels 1..N_CH-1 round-robin among themselves only when channel 0 is not requesting, and `ptr` never selects channel 0.
- **Macro undefined:** pure round-robin over all channels as described above.

## Test plan
- **Single read:** ch2 requests addr 0x00103, byte size; L2 grants immediately and returns 0xAABBCCDD → `l2_addr_o` = 0x00100, `ch_gnt_o` = 0b0100, then `ch_valid_o` = 0b0100 with `ch_data_o` = 0x000000AA.
- **Round-robin fairness:** all 4 channels request continuously, `l2_gnt_i` tied high, response latency 1 → grant order 0,1,2,3,0,1, with a gap of 2 cycles between grants (macro off).
- **Outstanding limit:** with OUTSTD = 2, rvalid withheld → exactly 2 grants and then `l2_req_o` stays 0. Releasing one rvalid leads to the third lock 1 cycle later. Two rvalids given in the same cycles as two further grants keep `cnt` at 2 (push/pop same cycle).
- **Held lock:** `l2_gnt_i` withheld 5 cycles while ch1 holds its request → `l2_req_o` and `l2_addr_o` stay stable for all 5 cycles, with a single `ch_gnt_o[1]` pulse on the grant.
- **Alignment:** half read at addr 0x...2 of data 0x12345678 → 0x00001234; word read at 0x...0 → 0x12345678.
- **Reset:** reset asserted with 2 reads outstanding, followed by 2 stray rvalids → `ch_valid_o` stays 0 and `cnt` = 0. With `UDMA_TX_ARB_PRIO_EN` defined, ch0 and ch3 requesting continuously → ch0 wins every arbitration.
